spi_slave_ng: RTL

//  Parametrised SPI target for the ICD path, a drop-in successor to the fixed 8-bit mode-0 target.

---
 rtl/spi_slave_ng.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_ng.sv
// spi_slave_ng
//   Parametrised SPI target. It sits between the oversampled ICD pins and the
//   ICD protocol engine. Word width, the four SPI modes and the bit order are
//   all set by parameters. TX words are taken through a single-entry holding
//   register with a ready/valid handshake. When a word load finds the holding
//   register empty, the target sends TX_IDLE and reports an underrun. When CSN
//   rises in the middle of a word, the target reports an abort.
//
// Ports
//   clk6x             system clock
//   resetn            asynchronous active-low reset
//   spi_clk_i         SCK pin (asynchronous)
//   spi_csn_i         chip select pin, active low (asynchronous)
//   spi_mosi_i        MOSI pin (asynchronous)
//   spi_miso_o        MISO data
//   spi_miso_drive_o  MISO output enable for the top-level tristate
//   rx_word_o         last complete received word
//   rx_hdr_en_o       pulse: first word after CSN fall is on rx_word_o
//   rx_db_en_o        pulse: a following word is on rx_word_o
//   rx_abort_o        pulse: CSN rose with a partial word received
//   tx_word_i         next word to transmit
//   tx_valid_i        tx_word_i valid
//   tx_ready_o        holding register empty
//   tx_underrun_o     pulse: a word load found holding empty, TX_IDLE used
//   busy_o            synchronised CSN active

module spi_slave_ng #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          LSB_FIRST = 1'b0,
    parameter logic [31:0] TX_IDLE   = 32'h0000_00FF
) (
    input  logic              clk6x,
    input  logic              resetn,
    input  logic              spi_clk_i,
    input  logic              spi_csn_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_drive_o,
    output logic [DATA_W-1:0] rx_word_o,
    output logic              rx_hdr_en_o,
    output logic              rx_db_en_o,
    output logic              rx_abort_o,
    input  logic [DATA_W-1:0] tx_word_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int unsigned       CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_W);
    localparam logic [DATA_W-1:0] TX_IDLE_W = DATA_W'(TX_IDLE);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t            state_q, state_d;
    logic              sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic              csn_meta_q, csn_meta_d, csn_sync_q, csn_sync_d;
    logic              mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              miso_q, miso_d;
    logic              hdr_q, hdr_d, db_q, db_d, abort_q, abort_d, underrun_q, underrun_d;

    logic sck_lead, sck_trail, sample_edge, shift_edge, word_load;

    // Bit presented on MISO for a given shift-register content.
    function automatic logic out_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w, input logic b);
        return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // Leading edge leaves the idle level. Trailing edge returns to it.
    assign sck_lead    = (sck_sync_q != CPOL) && (sck_prev_q == CPOL);
    assign sck_trail   = (sck_sync_q == CPOL) && (sck_prev_q != CPOL);
    assign sample_edge = CPHA ? sck_trail : sck_lead;
    assign shift_edge  = CPHA ? sck_lead  : sck_trail;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        sck_meta_d  = spi_clk_i;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        csn_meta_d  = spi_csn_i;
        csn_sync_d  = csn_meta_q;
        mosi_meta_d = spi_mosi_i;
        mosi_sync_d = mosi_meta_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        rx_shift_d  = rx_shift_q;
        rx_word_d   = rx_word_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        hdr_d       = 1'b0;
        db_d        = 1'b0;
        abort_d     = 1'b0;
        underrun_d  = 1'b0;
        word_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                first_d = 1'b1;
                // In leading-edge-sample modes, bit 0 must already be on MISO
                // before the first SCK edge. Keep the shift register primed.
                if (!CPHA) begin
                    tx_shift_d = hold_full_q ? hold_q : TX_IDLE_W;
                end
                if (!csn_sync_q) begin
                    state_d   = ST_ACTIVE;
                    word_load = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (cnt_q == CNT_FULL) begin
                    rx_word_d = rx_shift_q;
                    hdr_d     = first_q;
                    db_d      = !first_q;
                    first_d   = 1'b0;
                    cnt_d     = '0;
                end

                if (csn_sync_q) begin
                    // Any partial word is discarded. A word already in the TX
                    // shift register is dropped.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    abort_d = (cnt_q != '0) && (cnt_q != CNT_FULL);
                end else if (cnt_q == CNT_FULL) begin
                    word_load = 1'b1;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_insert(rx_shift_q, mosi_sync_q);
                        cnt_d      = cnt_q + 1'b1;
                    end
                    if (shift_edge) begin
                        if (CPHA) begin
                            miso_d     = out_bit(tx_shift_q);
                            tx_shift_d = tx_advance(tx_shift_q);
                        end else if (cnt_q != '0) begin
                            // A trailing edge with the counter at zero follows a
                            // fresh load. Bit 0 of the new word is already out.
                            tx_shift_d = tx_advance(tx_shift_q);
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (word_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = TX_IDLE_W;
                underrun_d = 1'b1;
            end
        end

        // Accept only into an empty holding register. A word offered in the
        // same cycle as an underrun load waits there for the next load.
        if (tx_valid_i && !hold_full_q) begin
            hold_d      = tx_word_i;
            hold_full_d = 1'b1;
        end

        if (!CPHA) begin
            miso_d = out_bit(tx_shift_d);
        end
    end

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sck_meta_q  <= CPOL;
            sck_sync_q  <= CPOL;
            sck_prev_q  <= CPOL;
            csn_meta_q  <= 1'b1;
            csn_sync_q  <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            rx_shift_q  <= '0;
            rx_word_q   <= '0;
            tx_shift_q  <= '0;
            // NOTE: the holding data is qualified by hold_full_q. It is still reset so that nothing X ever reaches MISO.
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            hdr_q       <= 1'b0;
            db_q        <= 1'b0;
            abort_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment, so every flop sees pre-edge values.
            state_q     <= state_d;
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            csn_meta_q  <= csn_meta_d;
            csn_sync_q  <= csn_sync_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            rx_shift_q  <= rx_shift_d;
            rx_word_q   <= rx_word_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            hdr_q       <= hdr_d;
            db_q        <= db_d;
            abort_q     <= abort_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_miso_o       = miso_q;
    assign spi_miso_drive_o = (state_q == ST_ACTIVE);
    assign rx_word_o        = rx_word_q;
    assign rx_hdr_en_o      = hdr_q;
    assign rx_db_en_o       = db_q;
    assign rx_abort_o       = abort_q;
    assign tx_ready_o       = !hold_full_q;
    assign tx_underrun_o    = underrun_q;
    assign busy_o           = !csn_sync_q;

endmodule
